// File: rtl/display_mode_ctrl.sv
// Frame-synchronous display mode selector: debounced key / switch request, applied at VSYNC_N fall.
// Optional AUTO_CYCLE_EN macro adds an auto-advance frame counter (AUTO_FRAMES frames without a press).
module display_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int AUTO_FRAMES     = 180
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       KEY_N,
    input  logic [1:0] SW,
    input  logic       SW_MODE,
    input  logic       VSYNC_N,
    output logic [1:0] mode_sel,
    output logic       mode_pending,
    output logic       frame_start,
    output logic       press
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    // Display cycle order; blank (11) is skipped when advancing.
    function automatic logic [1:0] next_mode(input logic [1:0] cur);
        logic [1:0] nxt;
        case (cur)
            2'b00:   nxt = 2'b01;
            2'b01:   nxt = 2'b10;
            2'b10:   nxt = 2'b00;
            default: nxt = 2'b00;
        endcase
        return nxt;
    endfunction

    logic            key_meta_q, key_sync_q;
    logic            vs_meta_q, vs_sync_q, vs_prev_q;
    logic [1:0]      sw_meta_q, sw_sync_q;
    logic            swm_meta_q, swm_sync_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            key_stable_q, key_stable_d;
    logic            key_prev_q, key_prev_d;
    logic            press_q, press_d;
    logic            frame_start_q, frame_start_d;
    logic [1:0]      target_q, target_d;
    logic [1:0]      mode_sel_q, mode_sel_d;
    state_t          state_q, state_d;
    logic            frame_fall_s;
    logic            auto_adv_s;

    // Two-flop synchronisers for all asynchronous board inputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
            vs_meta_q  <= 1'b1;
            vs_sync_q  <= 1'b1;
            sw_meta_q  <= 2'b00;
            sw_sync_q  <= 2'b00;
            swm_meta_q <= 1'b0;
            swm_sync_q <= 1'b0;
        end else begin
            key_meta_q <= KEY_N;
            key_sync_q <= key_meta_q;
            vs_meta_q  <= VSYNC_N;
            vs_sync_q  <= vs_meta_q;
            sw_meta_q  <= SW;
            sw_sync_q  <= sw_meta_q;
            swm_meta_q <= SW_MODE;
            swm_sync_q <= swm_meta_q;
        end
    end

    assign frame_fall_s = vs_prev_q & ~vs_sync_q;

    // Debounce counter and press detection on the falling edge of the stable level.
    always_comb begin
        db_cnt_d     = db_cnt_q;
        key_stable_d = key_stable_q;
        if (key_sync_q == key_stable_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            key_stable_d = key_sync_q;
            db_cnt_d     = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
        key_prev_d = key_stable_q;
        press_d    = key_prev_q & ~key_stable_q;
    end

`ifdef AUTO_CYCLE_EN
    localparam int              FC_W    = $clog2(AUTO_FRAMES + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(AUTO_FRAMES - 1);

    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;

    // Auto-advance fires in the frame-start cycle that completes AUTO_FRAMES idle frames.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        auto_adv_s  = 1'b0;
        if (swm_sync_q || press_q) begin
            frame_cnt_d = '0;
        end else if (frame_fall_s) begin
            if (frame_cnt_q == FC_LAST) begin
                auto_adv_s  = 1'b1;
                frame_cnt_d = '0;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Frame counter register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end
`else
    localparam int AUTO_FRAMES_UNUSED = AUTO_FRAMES;
    assign auto_adv_s = 1'b0;
`endif

    // Target, frame-synchronous select and pending FSM.
    always_comb begin
        target_d      = target_q;
        mode_sel_d    = mode_sel_q;
        frame_start_d = frame_fall_s;
        state_d       = state_q;
        if (swm_sync_q) begin
            target_d = sw_sync_q;
        end else if (press_q || auto_adv_s) begin
            target_d = next_mode(target_q);
        end else begin
            target_d = target_q;
        end
        // mode_sel takes the pre-update target, so a same-cycle advance stays pending.
        if (frame_fall_s) begin
            mode_sel_d = target_q;
        end else begin
            mode_sel_d = mode_sel_q;
        end
        if (target_d != mode_sel_d) begin
            state_d = PENDING;
        end else begin
            state_d = IDLE;
        end
    end

    // Main state registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            db_cnt_q      <= '0;
            key_stable_q  <= 1'b1;
            key_prev_q    <= 1'b1;
            press_q       <= 1'b0;
            vs_prev_q     <= 1'b1;
            frame_start_q <= 1'b0;
            target_q      <= 2'b00;
            mode_sel_q    <= 2'b00;
            state_q       <= IDLE;
        end else begin
            db_cnt_q      <= db_cnt_d;
            key_stable_q  <= key_stable_d;
            key_prev_q    <= key_prev_d;
            press_q       <= press_d;
            vs_prev_q     <= vs_sync_q;
            frame_start_q <= frame_start_d;
            target_q      <= target_d;
            mode_sel_q    <= mode_sel_d;
            state_q       <= state_d;
        end
    end

    assign mode_sel     = mode_sel_q;
    assign mode_pending = (state_q == PENDING);
    assign frame_start  = frame_start_q;
    assign press        = press_q;

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Scoreboard bench for display_mode_ctrl: expected mode_sel per frame start is queued when VSYNC_N is driven.
module tb_display_mode_ctrl;

    localparam int DB = 4;
    localparam int AF = 2;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       KEY_N;
    logic [1:0] SW;
    logic       SW_MODE;
    logic       VSYNC_N;
    logic [1:0] mode_sel;
    logic       mode_pending;
    logic       frame_start;
    logic       press;

    int         err_cnt   = 0;
    int         chk_cnt   = 0;
    int         fs_cnt    = 0;
    int         press_cnt = 0;
    logic [1:0] exp_q[$];

    display_mode_ctrl #(.DEBOUNCE_CYCLES(DB), .AUTO_FRAMES(AF)) dut (
        .CLK(CLK), .RST_N(RST_N), .KEY_N(KEY_N), .SW(SW), .SW_MODE(SW_MODE),
        .VSYNC_N(VSYNC_N), .mode_sel(mode_sel), .mode_pending(mode_pending),
        .frame_start(frame_start), .press(press)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard consumer: every frame_start pops one expected mode_sel.
    always @(negedge CLK) begin
        if (RST_N) begin
            if (frame_start) begin
                fs_cnt++;
                if (exp_q.size() == 0) chk("sb_depth_at_fs", exp_q.size(), 32'd1);
                else                   chk("mode_sel_at_fs", mode_sel, exp_q.pop_front());
            end
            if (press) press_cnt++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic vsync_pulse(input logic [1:0] e);
        exp_q.push_back(e);
        VSYNC_N = 1'b0;
        cyc(4);
        VSYNC_N = 1'b1;
        cyc(6);
    endtask

    task automatic key_press();
        KEY_N = 1'b0;
        cyc(10);
        KEY_N = 1'b1;
        cyc(10);
    endtask

    initial begin
        RST_N = 1'b0; KEY_N = 1'b1; VSYNC_N = 1'b1; SW = 2'b00; SW_MODE = 1'b0;
        cyc(3);
        chk("rst_mode_sel", mode_sel, 32'd0);
        chk("rst_pending", mode_pending, 32'd0);
        chk("rst_frame_start", frame_start, 32'd0);
        chk("rst_press", press, 32'd0);
        RST_N = 1'b1;
        cyc(5);
        chk("idle_mode_sel", mode_sel, 32'd0);
        chk("idle_pending", mode_pending, 32'd0);

`ifdef AUTO_CYCLE_EN
        for (int f = 1; f <= 5; f++) begin
            vsync_pulse((f >= 5) ? 2'b10 : ((f >= 3) ? 2'b01 : 2'b00));
            if (f == 2) chk("auto_pending", mode_pending, 32'd1);
        end
        chk("auto_fs_cnt", fs_cnt, 32'd5);
        chk("auto_no_press", press_cnt, 32'd0);
`else
        vsync_pulse(2'b00);
        chk("first_fs_cnt", fs_cnt, 32'd1);

        // Bouncing key, then a settled low: exactly one press.
        for (int i = 0; i < 4; i++) begin
            KEY_N = 1'b0; cyc(2);
            KEY_N = 1'b1; cyc(2);
        end
        key_press();
        chk("bounce_press_cnt", press_cnt, 32'd1);
        chk("bounce_pending", mode_pending, 32'd1);
        chk("bounce_mode_sel", mode_sel, 32'd0);
        key_press();
        chk("p2_pending", mode_pending, 32'd1);
        key_press();
        chk("p3_pending", mode_pending, 32'd0);
        chk("p3_press_cnt", press_cnt, 32'd3);
        vsync_pulse(2'b00);
        chk("p3_fs_pending", mode_pending, 32'd0);

        // Clean press with latency check.
        KEY_N = 1'b0;
        repeat (6) @(posedge CLK);
        #1 chk("press_early", press, 32'd0);
        @(posedge CLK);
        #1 chk("press_latency", press, 32'd1);
        cyc(5);
        KEY_N = 1'b1;
        cyc(10);
        chk("clean_pending", mode_pending, 32'd1);

        // VSYNC_N latency: frame_start on the 3rd edge.
        exp_q.push_back(2'b01);
        VSYNC_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1 chk("fs_early", frame_start, 32'd0);
        chk("mode_sel_early", mode_sel, 32'd0);
        @(posedge CLK);
        #1 chk("fs_latency", frame_start, 32'd1);
        cyc(3);
        VSYNC_N = 1'b1;
        cyc(6);
        chk("vs_pending", mode_pending, 32'd0);
        chk("held_low_fs_cnt", fs_cnt, 32'd3);

        // Switch mode: blank requested, applied only at the next frame.
        SW = 2'b11; SW_MODE = 1'b1;
        cyc(5);
        chk("sw_pending", mode_pending, 32'd1);
        chk("sw_mode_sel_hold", mode_sel, 32'd1);
        vsync_pulse(2'b11);
        chk("sw_applied_pending", mode_pending, 32'd0);
        SW_MODE = 1'b0;
        key_press();
        chk("sw_press_cnt", press_cnt, 32'd5);
        chk("blank_next_pending", mode_pending, 32'd1);
        vsync_pulse(2'b00);

        // Press aligned with frame start while in mode 01.
        key_press();
        vsync_pulse(2'b01);
        exp_q.push_back(2'b01);
        KEY_N = 1'b0;
        cyc(4);
        VSYNC_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1 chk("align_press", press, 32'd1);
        chk("align_fs", frame_start, 32'd1);
        cyc(6);
        VSYNC_N = 1'b1;
        cyc(6);
        KEY_N = 1'b1;
        cyc(10);
        chk("align_mode_sel", mode_sel, 32'd1);
        chk("align_pending", mode_pending, 32'd1);
        vsync_pulse(2'b10);
        chk("align_applied_pending", mode_pending, 32'd0);
        chk("align_press_cnt", press_cnt, 32'd7);
`endif

        // Reset mid-debounce and mid-frame: everything discarded.
        KEY_N = 1'b0;
        cyc(4);
        VSYNC_N = 1'b0;
        @(posedge CLK);
        #1 RST_N = 1'b0;
        #1 chk("midrst_mode_sel", mode_sel, 32'd0);
        chk("midrst_pending", mode_pending, 32'd0);
        chk("midrst_fs", frame_start, 32'd0);
        chk("midrst_press", press, 32'd0);
        @(negedge CLK);
        KEY_N = 1'b1; VSYNC_N = 1'b1;
        cyc(3);
        RST_N = 1'b1;
        cyc(10);
        vsync_pulse(2'b00);
        chk("post_rst_pending", mode_pending, 32'd0);
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
